// File: rtl/aes_pkg.sv
// Shared AES helpers: legal state widths, ShiftRows row offsets and the
// column-major byte position used by every block in this slice.
package aes_pkg;

   localparam int NB_LEGAL [3] = '{4, 6, 8};

   function automatic bit nb_legal(input int nb);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3; i++)
         if (NB_LEGAL[i] == nb) ok = 1'b1;
      return ok;
   endfunction

   // Rijndael offsets C1..C3; only the 256-bit block widens rows 2 and 3.
   function automatic int shift_off(input int nb, input int r);
      case (r)
         1:       return 1;
         2:       return (nb == 8) ? 3 : 2;
         3:       return (nb == 8) ? 4 : 3;
         default: return 0;
      endcase
   endfunction

   // LSB of byte s[r][c]; byte s[0][0] sits at the top of the block.
   function automatic int byte_lsb(input int nb, input int r, input int c);
      return 32*nb - 8*(4*c + r) - 8;
   endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Upstream/downstream handshake bundle for shift_rows_pipe.
// in_inv exists only when SHIFT_ROWS_INV_EN is defined.
interface shift_rows_pipe_if #(
   parameter int NB    = 4,
   parameter int TAG_W = 4
);
   logic                in_valid;
   logic                in_ready;
   logic [32*NB-1:0]    in_data;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [32*NB-1:0]    out_data;
   logic [TAG_W-1:0]    out_tag;
`ifdef SHIFT_ROWS_INV_EN
   logic                in_inv;

   modport master (output in_valid, in_data, in_inv, in_tag, out_ready,
                   input  in_ready, out_valid, out_data, out_tag);
   modport slave  (input  in_valid, in_data, in_inv, in_tag, out_ready,
                   output in_ready, out_valid, out_data, out_tag);
`else
   modport master (output in_valid, in_data, in_tag, out_ready,
                   input  in_ready, out_valid, out_data, out_tag);
   modport slave  (input  in_valid, in_data, in_tag, out_ready,
                   output in_ready, out_valid, out_data, out_tag);
`endif
endinterface

// File: rtl/shift_rows_perm.sv
// Combinational (Inv)ShiftRows byte permutation for an NB-column state.
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [32*NB-1:0] data,
   input  logic             inv,
   output logic [32*NB-1:0] res
);

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("shift_rows_perm: NB must be 4, 6 or 8");
   end

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int DST   = byte_lsb(NB, r, c);
         localparam int SRC_F = byte_lsb(NB, r, (c + shift_off(NB, r)) % NB);
         localparam int SRC_I = byte_lsb(NB, r, (c + NB - shift_off(NB, r)) % NB);
         assign res[DST +: 8] = inv ? data[SRC_I +: 8] : data[SRC_F +: 8];
      end
   end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows stage with a 2-entry output/skid buffer.
// Define SHIFT_ROWS_INV_EN to add per-block InvShiftRows selection via in_inv.
module shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   shift_rows_pipe_if.slave bus
);

   localparam int BW = 32*NB;

   logic [BW-1:0]    perm_data;
   logic             inv;
   logic             accept;
   logic             xfer;

   logic             out_vld_q,  out_vld_d;
   logic [BW-1:0]    out_data_q, out_data_d;
   logic [TAG_W-1:0] out_tag_q,  out_tag_d;
   logic             skid_vld_q,  skid_vld_d;
   logic [BW-1:0]    skid_data_q, skid_data_d;
   logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;

`ifdef SHIFT_ROWS_INV_EN
   assign inv = bus.in_inv;
`else
   assign inv = 1'b0;
`endif

   // Permuting before the buffer means each entry already holds the result
   // for its own direction, so the per-block choice travels with the data.
   shift_rows_perm #(.NB(NB)) u_perm (
      .data (bus.in_data),
      .inv  (inv),
      .res  (perm_data)
   );

   assign bus.in_ready  = !skid_vld_q;
   assign bus.out_valid = out_vld_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_tag   = out_tag_q;

   always_comb begin
      accept      = bus.in_valid && !skid_vld_q;
      xfer        = out_vld_q && bus.out_ready;
      out_vld_d   = out_vld_q;
      out_data_d  = out_data_q;
      out_tag_d   = out_tag_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_tag_d  = skid_tag_q;

      if (!out_vld_q || xfer) begin
         // Output slot frees: oldest block (skid) moves up first.
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = skid_data_q;
            out_tag_d  = skid_tag_q;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            out_vld_d  = 1'b1;
            out_data_d = perm_data;
            out_tag_d  = bus.in_tag;
         end else begin
            out_vld_d  = 1'b0;
         end
      end else if (accept) begin
         skid_vld_d  = 1'b1;
         skid_data_d = perm_data;
         skid_tag_d  = bus.in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_tag_q  <= '0;
      end else begin
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         skid_tag_q  <= skid_tag_d;
      end
   end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4 and NB=8 instances, directed vectors.
`timescale 1ns/1ps
module tb_shift_rows_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   shift_rows_pipe_if #(.NB(4), .TAG_W(4)) bus4 ();
   shift_rows_pipe_if #(.NB(8), .TAG_W(4)) bus8 ();

   shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   typedef struct {
      logic [255:0] data;
      logic [3:0]   tag;
   } exp_t;

   localparam logic [127:0] V_IN   = 128'hD42711AEE0BF98F1B8B45DE51E415230;
   localparam logic [127:0] V_OUT  = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
   localparam logic [127:0] B_IN   = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] B_OUT  = 128'h00050A0F04090E03080D02070C01060B;
   localparam logic [255:0] B8_IN  = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
   localparam logic [255:0] B8_OUT = 256'h00050E1304091217080D161B0C111A1F10151E0314190207181D060B1C010A0F;

   exp_t         sb4[$];
   exp_t         sb8[$];
   int           out_cyc4[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   logic [127:0] last4;
`ifdef SHIFT_ROWS_INV_EN
   logic         inv4 = 1'b0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Every byte gets high nibble n; the permutation is byte-wise so it commutes.
   function automatic logic [127:0] rep(input logic [3:0] n);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = {n, 4'h0};
      return r;
   endfunction

   task automatic send4(input logic [127:0] d, input logic [3:0] t, input logic [127:0] e);
      int waits;
      waits = 0;
      bus4.in_valid = 1'b1;
      bus4.in_data  = d;
      bus4.in_tag   = t;
`ifdef SHIFT_ROWS_INV_EN
      bus4.in_inv   = inv4;
`endif
      while (!bus4.in_ready && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      if (!bus4.in_ready) begin
         total++; bad++;
         $display("FAIL nb4_send_timeout: in_ready stuck low tag %0d", t);
      end else begin
         sb4.push_back('{data: 256'(e), tag: t});
         last4 = e;
         @(posedge clk); #1;
      end
      bus4.in_valid = 1'b0;
   endtask

   task automatic send8(input logic [255:0] d, input logic [3:0] t, input logic [255:0] e);
      int waits;
      waits = 0;
      bus8.in_valid = 1'b1;
      bus8.in_data  = d;
      bus8.in_tag   = t;
      while (!bus8.in_ready && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      if (!bus8.in_ready) begin
         total++; bad++;
         $display("FAIL nb8_send_timeout: in_ready stuck low tag %0d", t);
      end else begin
         sb8.push_back('{data: e, tag: t});
         @(posedge clk); #1;
      end
      bus8.in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus4.out_valid && bus4.out_ready) begin
         out_cyc4.push_back(cyc);
         if (sb4.size() == 0) begin
            total++; bad++;
            $display("FAIL nb4_unexpected: got %h tag %0d want nothing", bus4.out_data, bus4.out_tag);
         end else begin
            e = sb4.pop_front();
            check("nb4_data", 256'(bus4.out_data), e.data);
            check("nb4_tag", 256'(bus4.out_tag), 256'(e.tag));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus8.out_valid && bus8.out_ready) begin
         if (sb8.size() == 0) begin
            total++; bad++;
            $display("FAIL nb8_unexpected: got %h want nothing", bus8.out_data);
         end else begin
            e = sb8.pop_front();
            check("nb8_data", bus8.out_data, e.data);
            check("nb8_tag", 256'(bus8.out_tag), 256'(e.tag));
         end
      end
   end

   initial begin
      int start_c;
      int waits;
      bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_tag = '0; bus4.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_tag = '0; bus8.out_ready = 1'b1;
`ifdef SHIFT_ROWS_INV_EN
      bus4.in_inv = 1'b0; bus8.in_inv = 1'b0;
`endif
      last4 = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 256'(bus4.out_valid), 256'(0));
      check("rst_in_ready", 256'(bus4.in_ready), 256'(1));
      check("rst_out_data", 256'(bus4.out_data), 256'(0));
      check("rst_out_tag", 256'(bus4.out_tag), 256'(0));
      check("rst8_out_valid", 256'(bus8.out_valid), 256'(0));
      check("rst8_in_ready", 256'(bus8.in_ready), 256'(1));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 round vector, one-cycle latency
      send4(V_IN, 4'h1, V_OUT);
      check("nb4_latency_valid", 256'(bus4.out_valid), 256'(1));
      send4(B_IN, 4'h2, B_OUT);
`ifdef SHIFT_ROWS_INV_EN
      inv4 = 1'b1;
      send4(V_OUT, 4'h5, V_IN);
      inv4 = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("nb4_idle_valid", 256'(bus4.out_valid), 256'(0));
      check("nb4_idle_hold", 256'(bus4.out_data), 256'(last4));

      // NB=8 uses offsets 1,3,4
      send8(B8_IN, 4'h3, B8_OUT);
      check("nb8_r3c0", 256'(bus8.out_data[255-24 -: 8]), 256'(8'h13));
      check("nb8_r2c0", 256'(bus8.out_data[255-16 -: 8]), 256'(8'h0E));
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: two accepts fill the buffer, third waits
      bus4.out_ready = 1'b0;
      send4(B_IN | rep(4'h1), 4'h6, B_OUT | rep(4'h1));
      send4(B_IN | rep(4'h2), 4'h7, B_OUT | rep(4'h2));
      bus4.in_valid = 1'b1; bus4.in_data = B_IN | rep(4'h3); bus4.in_tag = 4'h8;
      check("stall_in_ready", 256'(bus4.in_ready), 256'(0));
      check("stall_out_data", 256'(bus4.out_data), 256'(B_OUT | rep(4'h1)));
      @(posedge clk); #1;
      check("stall_hold_valid", 256'(bus4.out_valid), 256'(1));
      check("stall_hold_data", 256'(bus4.out_data), 256'(B_OUT | rep(4'h1)));
      check("stall_hold_tag", 256'(bus4.out_tag), 256'(6));
      check("stall_in_ready2", 256'(bus4.in_ready), 256'(0));
      bus4.out_ready = 1'b1;
      send4(B_IN | rep(4'h3), 4'h8, B_OUT | rep(4'h3));
      repeat (4) @(posedge clk);
      #1;

      // Back-to-back throughput
      out_cyc4.delete();
      start_c = cyc;
      for (int i = 0; i < 16; i++)
         send4(B_IN | rep(4'(i)), 4'(i), B_OUT | rep(4'(i)));
      check("b2b_accept_cycles", 256'(cyc - start_c), 256'(16));
      repeat (3) @(posedge clk);
      #1;
      check("b2b_out_count", 256'(out_cyc4.size()), 256'(16));
      if (out_cyc4.size() == 16)
         check("b2b_out_span", 256'(out_cyc4[15] - out_cyc4[0]), 256'(15));

      // Reset with two held blocks and a third offered in the reset cycle
      bus4.out_ready = 1'b0;
      send4(B_IN | rep(4'h4), 4'h9, B_OUT | rep(4'h4));
      send4(B_IN | rep(4'h5), 4'hA, B_OUT | rep(4'h5));
      check("pre_rst_in_ready", 256'(bus4.in_ready), 256'(0));
      bus4.in_valid = 1'b1; bus4.in_data = B_IN | rep(4'h6); bus4.in_tag = 4'hB;
      rst_n = 1'b0;
      sb4.delete();
      @(posedge clk); #1;
      check("mid_rst_out_valid", 256'(bus4.out_valid), 256'(0));
      check("mid_rst_in_ready", 256'(bus4.in_ready), 256'(1));
      check("mid_rst_out_data", 256'(bus4.out_data), 256'(0));
      check("mid_rst_out_tag", 256'(bus4.out_tag), 256'(0));
      rst_n = 1'b1;
      bus4.in_valid = 1'b0;
      bus4.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_out_valid", 256'(bus4.out_valid), 256'(0));

      waits = 0;
      while ((sb4.size() != 0 || sb8.size() != 0) && waits < 50) begin
         @(posedge clk);
         waits++;
      end
      if (sb4.size() != 0 || sb8.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: got %0d/%0d pending want 0/0", sb4.size(), sb8.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4: state columns; legal values 4, 6, 8; block width BW = 32*NB.
REQ-002 SHALL have parameter TAG_W, default 4: width of sideband tag carried with each block.
REQ-003 SHALL have port clk  input  1  the single clock, all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  input block present.
REQ-006 SHALL have port in_ready  output  1  block can be accepted this cycle.
REQ-007 SHALL have port in_data  input  BW  state, column-major; byte s[r][c] at in_data[BW-1-8*(4c+r) -: 8].
REQ-008 SHALL have port in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows (exists only with SHIFT_ROWS_INV_EN).
REQ-009 SHALL have port in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-010 SHALL have port out_valid  output  1  output block present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_data  output  BW  shifted state, same byte layout.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the block on out_data.

Function
REQ-014 SHALL use row offsets C1..C3 of 1,2,3 for NB=4 and NB=6, and 1,3,4 for NB=8; row 0 is not shifted.
REQ-015 SHALL compute forward: s'[r][c] = s[r][(c+Cr) mod NB]; inverse: s'[r][c] = s[r][(c-Cr) mod NB].
REQ-016 SHALL accept a block when in_valid && in_ready, and transfer one out when out_valid && out_ready.
REQ-017 SHALL register the shifted result: latency exactly 1 cycle from accept to out_valid when the output stage is empty.
REQ-018 SHALL contain a 2-entry buffer (output register plus skid register) so that in_ready depends only on registered state, never combinationally on out_ready.
REQ-019 SHALL sustain one block per cycle while out_ready stays high.
REQ-020 SHALL drive in_ready low only when both entries are full.
REQ-021 SHALL, on simultaneous accept and transfer with one entry held, keep occupancy at 1 and present the new block next cycle.
REQ-022 SHALL, when out_ready drops, hold out_data/out_tag/out_valid stable until transfer; it SHALL drop no block and reorder no blocks.
REQ-023 SHALL keep out_data and out_tag unchanged while out_valid is low (no X propagation, no toggling).

Reset
REQ-024 SHALL, when rst_n is low at a clock edge, clear both entries: out_valid=0, in_ready=1 the next cycle, out_data=0, out_tag=0.
REQ-025 SHALL discard any held block when reset is asserted mid-operation; no block accepted in the reset cycle.

Configuration
REQ-026 SHALL, with macro SHIFT_ROWS_INV_EN defined, provide in_inv, store it per entry, and select the direction per block.
REQ-027 SHALL, without SHIFT_ROWS_INV_EN, omit in_inv and perform forward ShiftRows only.

Structure
REQ-028 SHALL place the byte-index helper, the NB-dependent offset table and the legal-NB check constants in shared package aes_pkg.
REQ-029 SHALL implement the combinational permutation as sub-module shift_rows_perm (parameters NB; inputs data, inv), instantiated once ahead of the buffer.
REQ-030 SHALL fail elaboration for NB outside {4,6,8}.

Verification
REQ-031 SHALL check: NB=4, forward, in_data=D42711AEE0BF98F1B8B45DE51E415230 -> out_data=D4BF5D30E0B452AEB84111F11E2798E5 one cycle later.
REQ-032 SHALL check: with SHIFT_ROWS_INV_EN, inverse of D4BF5D30E0B452AEB84111F11E2798E5 -> D42711AEE0BF98F1B8B45DE51E415230, tag 0x5 preserved.
REQ-033 SHALL check: NB=8, in_data bytes 00..1F ascending -> row 3 byte at column 0 equals 0x13 (s[3][4]), row 2 byte at column 0 equals 0x0E (s[2][3]).
REQ-034 SHALL check: out_ready low for 3 cycles with 3 blocks offered -> in_ready low after 2 accepts; all 3 blocks then emerge in order with their tags.
REQ-035 SHALL check: 16 back-to-back blocks, out_ready always high -> 16 outputs in 16 consecutive cycles.
REQ-036 SHALL check: rst_n low while 2 blocks are held -> out_valid=0, in_ready=1 next cycle, held blocks never appear.
